// File: rtl/traffic_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : traffic_run_ctrl
// Brief    : Run controller for NoC traffic experiments. Steps a run through
//            IDLE -> RST -> SEND -> COOL -> DONE and, during SEND, hands fixed
//            interval injection slots round-robin to the ready nodes.
// Ports    : clk, reset (sync, active-high), start, abort,
//            node_ready[NUM_NODES]  -> net_reset, send, inject[NUM_NODES]
//            (one-hot strobe), phase[3], done, inj_count[CNT_W]
//            optional stall_count[CNT_W] when TRAFFIC_RUN_CTRL_STATS_EN is
//            defined (SEND slots that found no ready node).
// Revision : 1.0  initial release
// ============================================================================
module traffic_run_ctrl #(
    parameter int NUM_NODES       = 9,
    parameter int RESET_CYCLES    = 10,
    parameter int SIM_CYCLES      = 10000,
    parameter int COOLDOWN_CYCLES = 5000,
    parameter int INJ_INTERVAL    = 4,
    parameter int CNT_W           = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [NUM_NODES-1:0] node_ready,
    output logic                 net_reset,
    output logic                 send,
    output logic [NUM_NODES-1:0] inject,
    output logic [2:0]           phase,
    output logic                 done,
    output logic [CNT_W-1:0]     inj_count
`ifdef TRAFFIC_RUN_CTRL_STATS_EN
    ,
    output logic [CNT_W-1:0]     stall_count
`endif
);

    localparam int PTR_W = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
    localparam int IW    = (INJ_INTERVAL > 1) ? $clog2(INJ_INTERVAL) : 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RST  = 3'd1,
        ST_SEND = 3'd2,
        ST_COOL = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [31:0]            cnt_q, cnt_d;
    logic [IW-1:0]          icnt_q, icnt_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic                   net_reset_q, net_reset_d;
    logic                   send_q, send_d;
    logic [NUM_NODES-1:0]   inject_q, inject_d;
    logic                   done_q, done_d;
    logic [CNT_W-1:0]       inj_count_q, inj_count_d;
`ifdef TRAFFIC_RUN_CTRL_STATS_EN
    logic [CNT_W-1:0]       stall_count_q, stall_count_d;
`endif

    // Arbitration scratch
    logic [PTR_W-1:0]       search_base;
    logic                   slot_due;
    logic                   found;
    int                     grant_idx;
    logic [2*NUM_NODES-1:0] rot;

    // The strobe is registered, so the slot decision for the next cycle is
    // taken here from the next-state values (state_d / icnt_d). A slot due
    // in SEND cycle k therefore strobes in cycle k itself, which lets the
    // final SEND cycle carry an inject without any strobe leaking into COOL.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        icnt_d      = icnt_q;
        ptr_d       = ptr_q;
        inj_count_d = inj_count_q;
        inject_d    = '0;
        search_base = ptr_q;
        slot_due    = 1'b0;
        found       = 1'b0;
        grant_idx   = 0;
        rot         = '0;
`ifdef TRAFFIC_RUN_CTRL_STATS_EN
        stall_count_d = stall_count_q;
`endif

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // start has priority; abort is not looked at here
                if (start) begin
                    state_d     = ST_RST;
                    cnt_d       = 32'(RESET_CYCLES - 1);
                    inj_count_d = '0;
`ifdef TRAFFIC_RUN_CTRL_STATS_EN
                    stall_count_d = '0;
`endif
                end
            end
            ST_RST: begin
                if (abort) begin
                    state_d = ST_COOL;
                    cnt_d   = 32'(COOLDOWN_CYCLES - 1);
                end else if (cnt_q == '0) begin
                    state_d     = ST_SEND;
                    cnt_d       = 32'(SIM_CYCLES - 1);
                    icnt_d      = IW'(INJ_INTERVAL - 1);
                    ptr_d       = '0;
                    search_base = '0;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            ST_SEND: begin
                // icnt_q == 0 marks a slot cycle; reload only once granted,
                // otherwise hold at zero so the slot retries every cycle.
                if (icnt_q != '0) begin
                    icnt_d = icnt_q - 1'b1;
                end else if (inject_q != '0) begin
                    icnt_d = IW'(INJ_INTERVAL - 1);
                end else begin
                    icnt_d = '0;
                end
                if (abort || (cnt_q == '0)) begin
                    state_d = ST_COOL;
                    cnt_d   = 32'(COOLDOWN_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            ST_COOL: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        slot_due = (state_d == ST_SEND) && (icnt_d == '0);
        if (slot_due) begin
            // Rotate a doubled copy so bit 0 is the pointer position, then
            // take the first set bit walking upward (wraps naturally).
            rot = {node_ready, node_ready} >> search_base;
            for (int i = 0; i < NUM_NODES; i++) begin
                if (!found && rot[0]) begin
                    found     = 1'b1;
                    grant_idx = int'(search_base) + i;
                end
                rot = rot >> 1;
            end
            if (grant_idx >= NUM_NODES) begin
                grant_idx = grant_idx - NUM_NODES;
            end
            if (found) begin
                inject_d    = NUM_NODES'(1) << grant_idx;
                ptr_d       = (grant_idx == NUM_NODES - 1) ? '0 : PTR_W'(grant_idx + 1);
                inj_count_d = (&inj_count_q) ? inj_count_q : inj_count_q + CNT_W'(1);
            end
`ifdef TRAFFIC_RUN_CTRL_STATS_EN
            else begin
                stall_count_d = (&stall_count_q) ? stall_count_q
                                                 : stall_count_q + CNT_W'(1);
            end
`endif
        end

        net_reset_d = (state_d == ST_IDLE) || (state_d == ST_RST);
        send_d      = (state_d == ST_SEND);
        done_d      = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            icnt_q      <= '0;
            ptr_q       <= '0;
            net_reset_q <= 1'b1;
            send_q      <= 1'b0;
            inject_q    <= '0;
            done_q      <= 1'b0;
            inj_count_q <= '0;
`ifdef TRAFFIC_RUN_CTRL_STATS_EN
            stall_count_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            icnt_q      <= icnt_d;
            ptr_q       <= ptr_d;
            net_reset_q <= net_reset_d;
            send_q      <= send_d;
            inject_q    <= inject_d;
            done_q      <= done_d;
            inj_count_q <= inj_count_d;
`ifdef TRAFFIC_RUN_CTRL_STATS_EN
            stall_count_q <= stall_count_d;
`endif
        end
    end

    assign net_reset = net_reset_q;
    assign send      = send_q;
    assign inject    = inject_q;
    assign phase     = state_q;
    assign done      = done_q;
    assign inj_count = inj_count_q;
`ifdef TRAFFIC_RUN_CTRL_STATS_EN
    assign stall_count = stall_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_traffic_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_run_ctrl
// Brief    : Self-checking bench for traffic_run_ctrl. Each run pushes the
//            expected per-cycle outputs into a scoreboard queue when start is
//            driven; the queue is popped and compared every cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_traffic_run_ctrl;

    localparam int N    = 4;
    localparam int RSTC = 3;
    localparam int SIMC = 20;
    localparam int COOL = 5;
    localparam int INJ  = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         abort;
    logic [N-1:0] node_ready;
    logic         net_reset;
    logic         send;
    logic [N-1:0] inject;
    logic [2:0]   phase;
    logic         done;
    logic [31:0]  inj_count;

    traffic_run_ctrl #(
        .NUM_NODES      (N),
        .RESET_CYCLES   (RSTC),
        .SIM_CYCLES     (SIMC),
        .COOLDOWN_CYCLES(COOL),
        .INJ_INTERVAL   (INJ),
        .CNT_W          (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .node_ready(node_ready),
        .net_reset (net_reset),
        .send      (send),
        .inject    (inject),
        .phase     (phase),
        .done      (done),
        .inj_count (inj_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]   ph;
        logic         nr;
        logic         s;
        logic [N-1:0] inj;
        logic         d;
        logic [31:0]  cnt;
    } obs_t;

    obs_t         exp_q[$];
    logic [N-1:0] plan [SIMC];   // ready vector seen by the slot of SEND cycle k
    int           checks   = 0;
    int           failures = 0;

    function automatic obs_t mk(input logic [2:0] ph, input logic nr, input logic s,
                                input logic [N-1:0] inj, input logic d, input int cnt);
        obs_t o;
        o.ph = ph; o.nr = nr; o.s = s; o.inj = inj; o.d = d; o.cnt = 32'(cnt);
        return o;
    endfunction

    function automatic obs_t sample();
        return mk(phase, net_reset, send, inject, done, int'(inj_count));
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("ph=%0d nr=%b send=%b inj=%b done=%b cnt=%0d",
                         o.ph, o.nr, o.s, o.inj, o.d, o.cnt);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference behaviour of one run, cycle by cycle from the first RST cycle.
    task automatic build_expect(input int abort_at, input int reset_at);
        int ptr = 0;
        int next_due = INJ - 1;
        int cnt = 0;
        int last_k = SIMC - 1;
        logic [N-1:0] inj;
        if (abort_at >= 0) last_k = abort_at;
        if (reset_at >= 0) last_k = reset_at;
        for (int t = 0; t < RSTC; t++) exp_q.push_back(mk(3'd1, 1'b1, 1'b0, '0, 1'b0, 0));
        for (int k = 0; k <= last_k; k++) begin
            inj = '0;
            if (k >= next_due) begin
                for (int j = 0; j < N; j++) begin
                    int n = (ptr + j) % N;
                    if (inj == '0 && ((plan[k] >> n) & 4'd1) != 4'd0) begin
                        inj      = 4'd1 << n;
                        ptr      = (n + 1) % N;
                        cnt      = cnt + 1;
                        next_due = k + INJ;
                    end
                end
            end
            exp_q.push_back(mk(3'd2, 1'b0, 1'b1, inj, 1'b0, cnt));
        end
        if (reset_at >= 0) begin
            exp_q.push_back(mk(3'd0, 1'b1, 1'b0, '0, 1'b0, 0));
            return;
        end
        for (int t = 0; t < COOL; t++) exp_q.push_back(mk(3'd3, 1'b0, 1'b0, '0, 1'b0, cnt));
        for (int t = 0; t < 2; t++)    exp_q.push_back(mk(3'd4, 1'b0, 1'b0, '0, 1'b1, cnt));
    endtask

    // Drive start for one cycle (from IDLE or DONE) and queue the expectation.
    task automatic start_run(input logic with_abort, input int abort_at, input int reset_at);
        build_expect(abort_at, reset_at);
        start = 1'b1; abort = with_abort; node_ready = '0;
        step();
        start = 1'b0; abort = 1'b0;
    endtask

    // Inputs for run cycle t: ready for the slot decided now, abort/reset.
    task automatic drive_cycle(input int t, input int abort_at, input int reset_at);
        int k = t - RSTC + 1;
        node_ready = (k >= 0 && k < SIMC) ? plan[k] : '0;
        abort      = (abort_at >= 0 && t == abort_at + RSTC);
        reset      = (reset_at >= 0 && t == reset_at + RSTC);
    endtask

    task automatic test_reset();
        obs_t a;
        obs_t e = mk(3'd0, 1'b1, 1'b0, '0, 1'b0, 0);
        reset = 1'b1; start = 1'b0; abort = 1'b0; node_ready = '1;
        step(); step();
        a = sample(); checks++;
        if (a !== e) begin failures++; $display("FAIL reset_hold got %s exp %s", fmt(a), fmt(e)); end
        reset = 1'b0;
        step();
        a = sample(); checks++;
        if (a !== e) begin failures++; $display("FAIL reset_after got %s exp %s", fmt(a), fmt(e)); end
        step();
        a = sample(); checks++;
        if (a !== e) begin failures++; $display("FAIL idle_hold got %s exp %s", fmt(a), fmt(e)); end
    endtask

    task automatic test_full_run();
        obs_t a, e;
        int t = 0;
        for (int k = 0; k < SIMC; k++) plan[k] = 4'b1111;
        start_run(1'b0, -1, -1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = sample(); checks++;
            if (a !== e) begin failures++; $display("FAIL full_run t=%0d got %s exp %s", t, fmt(a), fmt(e)); end
            if (exp_q.size() > 0) begin drive_cycle(t, -1, -1); step(); t++; end
        end
    endtask

    task automatic test_skip_not_ready();
        obs_t a, e;
        int t = 0;
        for (int k = 0; k < SIMC; k++) plan[k] = 4'b0101;
        start_run(1'b0, -1, -1);   // restart straight from DONE
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = sample(); checks++;
            if (a !== e) begin failures++; $display("FAIL skip_not_ready t=%0d got %s exp %s", t, fmt(a), fmt(e)); end
            if (exp_q.size() > 0) begin drive_cycle(t, -1, -1); step(); t++; end
        end
    endtask

    task automatic test_starvation();
        obs_t a, e;
        int t = 0;
        for (int k = 0; k < SIMC; k++) plan[k] = (k < 10) ? 4'b0000 : 4'b0010;
        start_run(1'b0, -1, -1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = sample(); checks++;
            if (a !== e) begin failures++; $display("FAIL starvation t=%0d got %s exp %s", t, fmt(a), fmt(e)); end
            if (exp_q.size() > 0) begin drive_cycle(t, -1, -1); step(); t++; end
        end
    endtask

    task automatic test_abort();
        obs_t a, e;
        int t = 0;
        for (int k = 0; k < SIMC; k++) plan[k] = 4'b1111;
        start_run(1'b0, 8, -1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = sample(); checks++;
            if (a !== e) begin failures++; $display("FAIL abort t=%0d got %s exp %s", t, fmt(a), fmt(e)); end
            if (exp_q.size() > 0) begin drive_cycle(t, 8, -1); step(); t++; end
        end
    endtask

    task automatic test_reset_mid_run();
        obs_t a, e;
        int t = 0;
        for (int k = 0; k < SIMC; k++) plan[k] = 4'b1111;
        start_run(1'b0, -1, 5);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = sample(); checks++;
            if (a !== e) begin failures++; $display("FAIL reset_mid t=%0d got %s exp %s", t, fmt(a), fmt(e)); end
            if (exp_q.size() > 0) begin drive_cycle(t, -1, 5); step(); t++; end
        end
        reset = 1'b0; node_ready = '0;
        step();
        e = mk(3'd0, 1'b1, 1'b0, '0, 1'b0, 0); a = sample(); checks++;
        if (a !== e) begin failures++; $display("FAIL reset_mid_idle got %s exp %s", fmt(a), fmt(e)); end
        // start and abort together in IDLE: start must win, run is normal
        t = 0;
        start_run(1'b1, -1, -1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = sample(); checks++;
            if (a !== e) begin failures++; $display("FAIL start_with_abort t=%0d got %s exp %s", t, fmt(a), fmt(e)); end
            if (exp_q.size() > 0) begin drive_cycle(t, -1, -1); step(); t++; end
        end
    endtask

    task automatic test_back_to_back();
        obs_t a, e;
        int t = 0;
        for (int k = 0; k < SIMC; k++) plan[k] = 4'b1111;
        start_run(1'b0, -1, -1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = sample(); checks++;
            if (a !== e) begin failures++; $display("FAIL back_to_back t=%0d got %s exp %s", t, fmt(a), fmt(e)); end
            if (exp_q.size() > 0) begin drive_cycle(t, -1, -1); step(); t++; end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; node_ready = '0;
        test_reset();
        test_full_run();
        test_skip_not_ready();
        test_starvation();
        test_abort();
        test_reset_mid_run();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
